// File: rtl/hamming_pkg.sv
// Shared types and sizes for the Hamming SECDED (16,11) encode/decode jobs.
package hamming_pkg;

    localparam int MSG_BITS = 11;
    localparam int CW_BITS  = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        WR_LO = 3'd3,
        WR_HI = 3'd4,
        DONE  = 3'd5
    } seq_state_t;

endpackage

// File: rtl/hamming_enc.sv
// Combinational SECDED (16,11) encoder: data bits fill the non-power-of-two
// positions, p1/p2/p4/p8 sit at positions 1/2/4/8 and p0 makes the word even.
module hamming_enc
    import hamming_pkg::*;
(
    input  logic [MSG_BITS:1]  d,
    output logic [CW_BITS-1:0] enc
);

    logic p8;
    logic p4;
    logic p2;
    logic p1;
    logic p0;

    // Parity generation and codeword assembly.
    always_comb begin
        p8  = ^d[11:5];
        p4  = (^d[11:8]) ^ (^d[4:2]);
        p2  = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
        p1  = d[11] ^ d[9]  ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
        p0  = (^d) ^ p8 ^ p4 ^ p2 ^ p1;
        enc = {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
    end

endmodule

// File: rtl/hamming_seq_ctrl.sv
// Program-1 sequencer: reads NUM_MSG 11-bit messages, SECDED-encodes them and
// writes the codewords back, owning the data-memory port while it runs.
module hamming_seq_ctrl
    import hamming_pkg::*;
#(
    parameter int unsigned AW       = 8,
    parameter int unsigned SRC_BASE = 0,
    parameter int unsigned DST_BASE = 30,
    parameter int unsigned NUM_MSG  = 15
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          done,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_wr_en,
    input  logic [7:0]    cpu_wdata,
    output logic          cpu_stall,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata
);

    localparam logic [AW-1:0] SRC      = AW'(SRC_BASE);
    localparam logic [AW-1:0] DST      = AW'(DST_BASE);
    localparam logic [AW-1:0] ADDR_ONE = AW'(1);
    localparam logic [AW-2:0] LAST_IDX = (AW-1)'(NUM_MSG - 1);
    localparam logic [AW-2:0] IDX_ONE  = (AW-1)'(1);

    seq_state_t           state;
    seq_state_t           next_state;
    logic                 start_q;
    logic                 launch;
    logic                 last;
    logic [AW-2:0]        msg_idx;
    logic [7:0]           lo_q;
    logic [2:0]           hi_q;
    logic [AW-1:0]        src_addr;
    logic [AW-1:0]        dst_addr;
    logic [MSG_BITS:1]    d;
    logic [CW_BITS-1:0]   enc;
    logic                 unused_rdata;

    assign launch       = start_q & ~start;
    assign last         = (msg_idx == LAST_IDX);
    assign src_addr     = SRC + {msg_idx, 1'b0};
    assign dst_addr     = DST + {msg_idx, 1'b0};
    assign d            = {hi_q, lo_q};
    assign unused_rdata = ^mem_rdata[7:3];

    hamming_enc u_enc (
        .d   (d),
        .enc (enc)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a start falling edge only matters while not running.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (launch) next_state = RD_LO; else next_state = IDLE;
            RD_LO:   next_state = RD_HI;
            RD_HI:   next_state = WR_LO;
            WR_LO:   next_state = WR_HI;
            WR_HI:   if (last) next_state = DONE; else next_state = RD_LO;
            DONE:    if (launch) next_state = RD_LO; else next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: start edge detect, message capture, index and done flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_q <= 1'b0;
            msg_idx <= {(AW-1){1'b0}};
            lo_q    <= 8'h00;
            hi_q    <= 3'b000;
            done    <= 1'b0;
        end else begin
            start_q <= start;
            case (state)
                IDLE, DONE: begin
                    if (launch) begin
                        msg_idx <= {(AW-1){1'b0}};
                        done    <= 1'b0;
                    end
                end
                RD_LO: lo_q <= mem_rdata;
                RD_HI: hi_q <= mem_rdata[2:0];
                WR_HI: begin
                    if (last) begin
                        done <= 1'b1;
                    end else begin
                        msg_idx <= msg_idx + IDX_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Port mux: core passes through when idle, otherwise the sequencer drives and the core stalls.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_wr_en = cpu_wr_en;
        mem_wdata = cpu_wdata;
        cpu_stall = 1'b0;
        case (state)
            IDLE, DONE: begin
                mem_addr  = cpu_addr;
                mem_wr_en = cpu_wr_en;
                mem_wdata = cpu_wdata;
                cpu_stall = 1'b0;
            end
            RD_LO: begin
                mem_addr  = src_addr;
                mem_wr_en = 1'b0;
                mem_wdata = 8'h00;
                cpu_stall = 1'b1;
            end
            RD_HI: begin
                mem_addr  = src_addr + ADDR_ONE;
                mem_wr_en = 1'b0;
                mem_wdata = 8'h00;
                cpu_stall = 1'b1;
            end
            WR_LO: begin
                mem_addr  = dst_addr;
                mem_wr_en = 1'b1;
                mem_wdata = enc[7:0];
                cpu_stall = 1'b1;
            end
            WR_HI: begin
                mem_addr  = dst_addr + ADDR_ONE;
                mem_wr_en = 1'b1;
                mem_wdata = enc[15:8];
                cpu_stall = 1'b1;
            end
            default: begin
                mem_wr_en = 1'b0;
                cpu_stall = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_hamming_seq_ctrl.sv
// Bench for hamming_seq_ctrl: behavioural 256x8 memory, randomized messages,
// positional Hamming reference model and a full sweep of the encoder.
module tb_hamming_seq_ctrl;

    localparam int SRC = 0;
    localparam int DST = 30;
    localparam int N   = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       done;
    logic [7:0] cpu_addr;
    logic       cpu_wr_en;
    logic [7:0] cpu_wdata;
    logic       cpu_stall;
    logic [7:0] mem_addr;
    logic       mem_wr_en;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    logic [7:0] mem [0:255];
    logic       bd_we = 1'b0;
    logic [7:0] bd_addr = 8'h00;
    logic [7:0] bd_data = 8'h00;

    logic [7:0] src_lo [N];
    logic [7:0] src_hi [N];

    logic [11:1] enc_d = 11'h000;
    logic [15:0] enc_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hamming_seq_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .done      (done),
        .cpu_addr  (cpu_addr),
        .cpu_wr_en (cpu_wr_en),
        .cpu_wdata (cpu_wdata),
        .cpu_stall (cpu_stall),
        .mem_addr  (mem_addr),
        .mem_wr_en (mem_wr_en),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    hamming_enc u_enc (
        .d   (enc_d),
        .enc (enc_out)
    );

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    end

    // Reference: data bits fill positions 3,5,6,7,9..15; parity bit 2^b covers positions with bit b set.
    function automatic logic [15:0] ref_enc(input logic [10:0] m);
        logic [15:0] cw;
        logic        p;
        int          k;
        cw = 16'h0000;
        k  = 0;
        for (int pos = 1; pos < 16; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                cw[pos] = m[k];
                k++;
            end
        end
        for (int b = 0; b < 4; b++) begin
            p = 1'b0;
            for (int pos = 1; pos < 16; pos++) if (pos[b]) p = p ^ cw[pos];
            cw[1 << b] = p;
        end
        cw[0] = ^cw[15:1];
        return cw;
    endfunction

    function automatic logic [4:0] ref_syn(input logic [15:0] cw);
        logic [3:0] s;
        s = 4'h0;
        for (int pos = 1; pos < 16; pos++) if (cw[pos]) s = s ^ pos[3:0];
        return {s, ^cw};
    endfunction

    function automatic logic [15:0] exp_word(input int i);
        return ref_enc({src_hi[i][2:0], src_lo[i]});
    endfunction

    function automatic logic [15:0] dst_word(input int i);
        return {mem[DST + 2*i + 1], mem[DST + 2*i]};
    endfunction

    task automatic poke(input int a, input logic [7:0] v);
        bd_addr = a[7:0];
        bd_data = v;
        bd_we   = 1'b1;
        @(posedge clk); #1;
        bd_we   = 1'b0;
    endtask

    task automatic set_msg(input int i, input logic [7:0] lo, input logic [7:0] hi);
        src_lo[i] = lo;
        src_hi[i] = hi;
        poke(SRC + 2*i, lo);
        poke(SRC + 2*i + 1, hi);
    endtask

    task automatic load_random();
        for (int i = 0; i < N; i++) set_msg(i, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    endtask

    // Falling edge on start, then count cycles from RD_LO to done (bounded).
    task automatic run_job(output int n, output int stall_bad, output logic done_at_launch);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        done_at_launch = done;
        n = 0;
        stall_bad = 0;
        while (done !== 1'b1 && n < 200) begin
            if (cpu_stall !== 1'b1) stall_bad++;
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1;
        cpu_addr = 8'h5A; cpu_wr_en = 1'b0; cpu_wdata = 8'hA5;
        #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", cpu_stall); end
        checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got=%b exp=0", mem_wr_en); end
        checks++; if (mem_addr !== 8'h5A || mem_wdata !== 8'hA5) begin
            errors++; $display("FAIL idle_passthru got=%h/%h exp=5a/a5", mem_addr, mem_wdata);
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0; start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (cpu_stall !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL no_launch_after_reset got stall=%b done=%b exp=0/0", cpu_stall, done);
        end
    endtask

    task automatic test_basic();
        int n, sb; logic dl;
        load_random();
        set_msg(0, 8'h00, 8'h00);
        set_msg(1, 8'hFF, 8'h07);
        set_msg(2, 8'h01, 8'h00);
        set_msg(3, 8'h00, 8'h04);
        run_job(n, sb, dl);
        checks++; if (n != 60) begin errors++; $display("FAIL basic_latency got=%0d exp=60", n); end
        checks++; if (sb != 0) begin errors++; $display("FAIL basic_stall got=%0d unstalled cycles exp=0", sb); end
        checks++; if (dst_word(0) !== 16'h0000) begin errors++; $display("FAIL basic_w0 got=%h exp=0000", dst_word(0)); end
        checks++; if (dst_word(1) !== 16'hFFFF) begin errors++; $display("FAIL basic_w1 got=%h exp=ffff", dst_word(1)); end
        checks++; if (dst_word(2) !== 16'h000F) begin errors++; $display("FAIL basic_w2 got=%h exp=000f", dst_word(2)); end
        checks++; if (dst_word(3) !== 16'h8117) begin errors++; $display("FAIL basic_w3 got=%h exp=8117", dst_word(3)); end
        for (int i = 4; i < N; i++) begin
            checks++; if (dst_word(i) !== exp_word(i)) begin
                errors++; $display("FAIL basic_word%0d got=%h exp=%h", i, dst_word(i), exp_word(i));
            end
        end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done_sticky got=%b exp=1", done); end
    endtask

    task automatic test_junk_hi();
        int n, sb; logic dl;
        load_random();
        set_msg(0, 8'h00, 8'hF8);
        run_job(n, sb, dl);
        checks++; if (dst_word(0) !== 16'h0000) begin errors++; $display("FAIL junk_hi got=%h exp=0000", dst_word(0)); end
        for (int i = 1; i < N; i++) begin
            checks++; if (dst_word(i) !== exp_word(i)) begin
                errors++; $display("FAIL junk_word%0d got=%h exp=%h", i, dst_word(i), exp_word(i));
            end
        end
    endtask

    task automatic test_cpu_stall();
        int n, sb;
        load_random();
        poke(100, 8'h55);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        cpu_addr = 8'd100; cpu_wdata = 8'hAA; cpu_wr_en = 1'b1;
        n = 0; sb = 0;
        while (done !== 1'b1 && n < 200) begin
            if (cpu_stall !== 1'b1) sb++;
            @(posedge clk); #1;
            n++;
        end
        checks++; if (sb != 0 || n != 60) begin errors++; $display("FAIL cpu_stall got unstalled=%0d len=%0d exp=0/60", sb, n); end
        checks++; if (mem[100] !== 8'h55) begin errors++; $display("FAIL cpu_blocked got=%h exp=55", mem[100]); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL cpu_stall_done got=%b exp=0", cpu_stall); end
        @(posedge clk); #1;
        cpu_wr_en = 1'b0;
        checks++; if (mem[100] !== 8'hAA) begin errors++; $display("FAIL cpu_write_after got=%h exp=aa", mem[100]); end
        for (int i = 0; i < N; i++) begin
            checks++; if (dst_word(i) !== exp_word(i)) begin
                errors++; $display("FAIL stall_word%0d got=%h exp=%h", i, dst_word(i), exp_word(i));
            end
        end
    endtask

    task automatic test_reset_midjob();
        int n, sb; logic dl;
        logic [15:0] w5;
        load_random();
        for (int a = DST; a < DST + 2*N; a++) poke(a, 8'hC3);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        repeat (23) @(posedge clk);
        #1;
        checks++; if (mem_wr_en !== 1'b1 || mem_addr !== 8'(DST + 11)) begin
            errors++; $display("FAIL midjob_wr_hi5 got=%b/%h exp=1/%h", mem_wr_en, mem_addr, 8'(DST + 11));
        end
        reset = 1'b1;
        #1;
        checks++; if (done !== 1'b0 || mem_wr_en !== 1'b0) begin
            errors++; $display("FAIL midjob_reset got done=%b wr=%b exp=0/0", done, mem_wr_en);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (dst_word(i) !== exp_word(i)) begin
                errors++; $display("FAIL midjob_word%0d got=%h exp=%h", i, dst_word(i), exp_word(i));
            end
        end
        w5 = exp_word(5);
        checks++; if (mem[DST + 10] !== w5[7:0]) begin errors++; $display("FAIL midjob_lo5 got=%h exp=%h", mem[DST + 10], w5[7:0]); end
        checks++; if (mem[DST + 11] !== 8'hC3) begin errors++; $display("FAIL midjob_hi5 got=%h exp=c3", mem[DST + 11]); end
        checks++; if (mem[DST + 12] !== 8'hC3) begin errors++; $display("FAIL midjob_lo6 got=%h exp=c3", mem[DST + 12]); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL midjob_no_resume got=%b exp=0", cpu_stall); end
        run_job(n, sb, dl);
        checks++; if (n != 60 || done !== 1'b1) begin errors++; $display("FAIL restart_latency got=%0d exp=60", n); end
        for (int i = 0; i < N; i++) begin
            checks++; if (dst_word(i) !== exp_word(i)) begin
                errors++; $display("FAIL restart_word%0d got=%h exp=%h", i, dst_word(i), exp_word(i));
            end
        end
    endtask

    task automatic test_back_to_back();
        int n, sb, rises, rise_at;
        logic prev, dl;
        logic [7:0] wr_log [$];
        load_random();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        n = 0; rises = 0; rise_at = -1; prev = done;
        wr_log.delete();
        while (n < 80) begin
            if (mem_wr_en && cpu_stall) wr_log.push_back(mem_addr);
            if (n < 50) start = 1'($urandom_range(0, 1));
            else start = 1'b0;
            @(posedge clk); #1;
            n++;
            if (done && !prev) begin rises++; rise_at = n; end
            prev = done;
        end
        checks++; if (rises != 1 || rise_at != 60) begin
            errors++; $display("FAIL toggle_done got rises=%0d at=%0d exp=1 at 60", rises, rise_at);
        end
        checks++; if (wr_log.size() != 2*N) begin errors++; $display("FAIL toggle_wr_count got=%0d exp=%0d", wr_log.size(), 2*N); end
        for (int k = 0; k < wr_log.size() && k < 2*N; k++) begin
            checks++; if (wr_log[k] !== 8'(DST + k)) begin
                errors++; $display("FAIL toggle_wr_addr%0d got=%h exp=%h", k, wr_log[k], 8'(DST + k));
            end
        end
        for (int i = 0; i < N; i++) begin
            checks++; if (dst_word(i) !== exp_word(i)) begin
                errors++; $display("FAIL toggle_word%0d got=%h exp=%h", i, dst_word(i), exp_word(i));
            end
        end
        load_random();
        run_job(n, sb, dl);
        checks++; if (dl !== 1'b0) begin errors++; $display("FAIL second_done_drop got=%b exp=0", dl); end
        checks++; if (n != 60 || done !== 1'b1) begin errors++; $display("FAIL second_latency got=%0d exp=60", n); end
        for (int i = 0; i < N; i++) begin
            checks++; if (dst_word(i) !== exp_word(i)) begin
                errors++; $display("FAIL second_word%0d got=%h exp=%h", i, dst_word(i), exp_word(i));
            end
        end
    endtask

    task automatic test_enc_sweep();
        logic [15:0] flipped;
        int bad;
        for (int v = 0; v < 2048; v++) begin
            enc_d = 11'(v);
            #1;
            checks++; if (enc_out !== ref_enc(11'(v))) begin
                errors++; $display("FAIL sweep_enc d=%h got=%h exp=%h", v, enc_out, ref_enc(11'(v)));
            end
            checks++; if (ref_syn(enc_out) !== 5'h00) begin
                errors++; $display("FAIL sweep_syn0 d=%h got=%h exp=00", v, ref_syn(enc_out));
            end
            bad = 0;
            for (int b = 0; b < 16; b++) begin
                flipped = enc_out ^ (16'h0001 << b);
                if (ref_syn(flipped) == 5'h00) bad++;
            end
            checks++; if (bad != 0) begin
                errors++; $display("FAIL sweep_flip d=%h got=%0d zero syndromes exp=0", v, bad);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_junk_hi();
        test_cpu_stall();
        test_reset_midjob();
        test_back_to_back();
        test_enc_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
